// File: rtl/epp_pkg.sv
// Shared types and constants for the EPP host-port front-end.
package epp_pkg;

    // Which phase of an EPP cycle the slave is in.
    typedef enum logic [2:0] {
        StIdle,
        StAwr,
        StArd,
        StDwr,
        StDrd,
        StAck
    } epp_state_e;

    // Register addresses of the NAND flash sequencer.
    localparam logic [7:0] ADDR_ADDR = 8'h41;
    localparam logic [7:0] ADDR_BUSY = 8'h42;
    localparam logic [7:0] ADDR_CMD  = 8'h43;
    localparam logic [7:0] ADDR_DATA = 8'h44;
    localparam logic [7:0] ADDR_CE   = 8'h45;

    // Byte the host reads back when a data read times out.
    localparam logic [7:0] TIMEOUT_RD_VAL = 8'hFF;

endpackage

// File: rtl/epp_sync.sv
// N-stage flip-flop synchroniser for an asynchronous bus, with a selectable reset value.
module epp_sync #(
    parameter int unsigned        Width    = 1,
    parameter int unsigned        Stages   = 2,
    parameter logic [Width-1:0]   ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= ResetVal;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/epp_slave.sv
// EPP host-port slave: turns each EPP address/data cycle into a clean backend transaction
// and completes the host wait handshake only once the backend has taken or supplied the byte.
module epp_slave
    import epp_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic       clk_ndf,
    input  logic       rst,
    input  logic       epp_astb_n,
    input  logic       epp_dstb_n,
    input  logic       epp_wr_n,
    input  logic [7:0] epp_d_i,
    output logic [7:0] epp_q_o,
    output logic       epp_oe,
    output logic       epp_wait_n,
    output logic [7:0] reg_addr,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       rd_req,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    output logic       timeout_err
);

    localparam int unsigned     CntW       = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

    logic       astb_s, dstb_s, wr_s;
    logic [7:0] d_s;

    // Strobes idle high, so their synchronisers reset to 1.
    epp_sync #(
        .Width    (3),
        .Stages   (SYNC_STAGES),
        .ResetVal (3'b111)
    ) u_sync_strb (
        .clk_i (clk_ndf),
        .rst_i (rst),
        .d_i   ({epp_astb_n, epp_dstb_n, epp_wr_n}),
        .q_o   ({astb_s, dstb_s, wr_s})
    );

    epp_sync #(
        .Width    (8),
        .Stages   (SYNC_STAGES),
        .ResetVal (8'h00)
    ) u_sync_data (
        .clk_i (clk_ndf),
        .rst_i (rst),
        .d_i   (epp_d_i),
        .q_o   (d_s)
    );

    epp_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            addr_cyc_q, addr_cyc_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            wr_valid_q, wr_valid_d;
    logic            rd_req_q, rd_req_d;
    logic [7:0]      epp_q_q, epp_q_d;
    logic            oe_q, oe_d;
    logic            wait_n_q, wait_n_d;
    logic            terr_q, terr_d;
    logic [CntW-1:0] cnt_inc;

    // Saturating increment; the FSM leaves DWR/DRD before it could ever wrap.
    assign cnt_inc = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + 1'b1;

    // State and output registers.
    always_ff @(posedge clk_ndf or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_cyc_q <= 1'b0;
            reg_addr_q <= 8'h00;
            wr_data_q  <= 8'h00;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            epp_q_q    <= 8'h00;
            oe_q       <= 1'b0;
            wait_n_q   <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_cyc_q <= addr_cyc_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
            epp_q_q    <= epp_q_d;
            oe_q       <= oe_d;
            wait_n_q   <= wait_n_d;
            terr_q     <= terr_d;
        end
    end

    // Next-state and next-output logic for the EPP cycle sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_cyc_d = addr_cyc_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q;
        rd_req_d   = rd_req_q;
        epp_q_d    = epp_q_q;
        oe_d       = oe_q;
        wait_n_d   = wait_n_q;
        terr_d     = terr_q;

        unique case (state_q)
            StIdle: begin
                // Both strobes low at once is a protocol error and is ignored.
                if (!astb_s && dstb_s) begin
                    addr_cyc_d = 1'b1;
                    state_d    = wr_s ? StArd : StAwr;
                end else if (!dstb_s && astb_s) begin
                    addr_cyc_d = 1'b0;
                    cnt_d      = '0;
                    if (!wr_s) begin
                        state_d    = StDwr;
                        wr_data_d  = d_s;
                        wr_valid_d = 1'b1;
                    end else begin
                        state_d  = StDrd;
                        rd_req_d = 1'b1;
                    end
                end
            end
            StAwr: begin
                reg_addr_d = d_s;
                terr_d     = 1'b0;
                wait_n_d   = 1'b1;
                state_d    = StAck;
            end
            StArd: begin
                epp_q_d  = reg_addr_q;
                oe_d     = 1'b1;
                wait_n_d = 1'b1;
                state_d  = StAck;
            end
            StDwr: begin
                // Acceptance wins over a timeout landing on the same cycle.
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    wait_n_d   = 1'b1;
                    state_d    = StAck;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutVal) begin
                        wr_valid_d = 1'b0;
                        terr_d     = 1'b1;
                        wait_n_d   = 1'b1;
                        state_d    = StAck;
                    end
                end
            end
            StDrd: begin
                if (rd_valid) begin
                    epp_q_d  = rd_data;
                    oe_d     = 1'b1;
                    rd_req_d = 1'b0;
                    wait_n_d = 1'b1;
                    state_d  = StAck;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutVal) begin
                        epp_q_d  = TIMEOUT_RD_VAL;
                        oe_d     = 1'b1;
                        rd_req_d = 1'b0;
                        terr_d   = 1'b1;
                        wait_n_d = 1'b1;
                        state_d  = StAck;
                    end
                end
            end
            StAck: begin
                // Hold the acknowledge until the strobe that opened this cycle is released.
                if (addr_cyc_q ? astb_s : dstb_s) begin
                    wait_n_d = 1'b0;
                    oe_d     = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign epp_q_o     = epp_q_q;
    assign epp_oe      = oe_q;
    assign epp_wait_n  = wait_n_q;
    assign reg_addr    = reg_addr_q;
    assign wr_valid    = wr_valid_q;
    assign wr_data     = wr_data_q;
    assign rd_req      = rd_req_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_epp_slave.sv
// Randomised bench for epp_slave: a host/backend driver plus a transaction-level model.
module tb_epp_slave;
    import epp_pkg::*;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned Timeout    = 15;

    logic       clk_ndf;
    logic       rst;
    logic       epp_astb_n, epp_dstb_n, epp_wr_n;
    logic [7:0] epp_d_i;
    logic [7:0] epp_q_o;
    logic       epp_oe, epp_wait_n;
    logic [7:0] reg_addr;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       timeout_err;

    epp_slave #(
        .SYNC_STAGES (SyncStages),
        .TIMEOUT     (Timeout)
    ) dut (
        .clk_ndf     (clk_ndf),
        .rst         (rst),
        .epp_astb_n  (epp_astb_n),
        .epp_dstb_n  (epp_dstb_n),
        .epp_wr_n    (epp_wr_n),
        .epp_d_i     (epp_d_i),
        .epp_q_o     (epp_q_o),
        .epp_oe      (epp_oe),
        .epp_wait_n  (epp_wait_n),
        .reg_addr    (reg_addr),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .timeout_err (timeout_err)
    );

    initial clk_ndf = 1'b0;
    always #25 clk_ndf = ~clk_ndf;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model of the slave's visible state.
    logic [7:0] m_addr = 8'h00;
    logic       m_terr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ndf);
        #1;
    endtask

    // Release the active strobe and check the acknowledge drops after the sync delay.
    task automatic release_strobe(input bit is_addr);
        int n;
        @(negedge clk_ndf);
        if (is_addr) epp_astb_n = 1'b1;
        else         epp_dstb_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (epp_wait_n && n < 50);
        check_eq("rel_lat", n, SyncStages + 1);
        check_eq("rel_oe", epp_oe, 1'b0);
        epp_wr_n = 1'b1;
        tick();
    endtask

    task automatic addr_write(input logic [7:0] b);
        int n;
        bit bad;
        @(negedge clk_ndf);
        epp_wr_n   = 1'b0;
        epp_d_i    = b;
        epp_astb_n = 1'b0;
        n   = 0;
        bad = 0;
        do begin
            tick();
            n++;
            if (wr_valid || rd_req) bad = 1;
        end while (!epp_wait_n && n < 50);
        m_addr = b;
        m_terr = 1'b0;
        check_eq("aw_lat", n, SyncStages + 2);
        check_eq("aw_addr", reg_addr, m_addr);
        check_eq("aw_terr", timeout_err, m_terr);
        check_eq("aw_nobe", bad, 1'b0);
        release_strobe(1'b1);
    endtask

    task automatic addr_read();
        int n;
        @(negedge clk_ndf);
        epp_wr_n   = 1'b1;
        epp_d_i    = 8'($urandom);
        epp_astb_n = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!epp_wait_n && n < 50);
        check_eq("ar_lat", n, SyncStages + 2);
        check_eq("ar_q", epp_q_o, m_addr);
        check_eq("ar_oe", epp_oe, 1'b1);
        release_strobe(1'b1);
    endtask

    // Backend accepts on the (delay+1)-th cycle of wr_valid, unless the timeout fires first.
    task automatic data_write(input logic [7:0] b, input int delay);
        int n, v, exp_v;
        bit bad;
        @(negedge clk_ndf);
        epp_wr_n   = 1'b0;
        epp_d_i    = b;
        epp_dstb_n = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wr_valid && n < 50);
        check_eq("dw_lat", n, SyncStages + 1);
        v   = 0;
        bad = 0;
        while (wr_valid && v < 60) begin
            v++;
            if (wr_data !== b || epp_wait_n || rd_req) bad = 1;
            if (v - 1 == delay) wr_ready = 1'b1;
            tick();
            wr_ready = 1'b0;
        end
        exp_v = (delay < int'(Timeout)) ? delay + 1 : int'(Timeout);
        if (delay >= int'(Timeout)) m_terr = 1'b1;
        check_eq("dw_cycles", v, exp_v);
        check_eq("dw_data", bad, 1'b0);
        check_eq("dw_wait", epp_wait_n, 1'b1);
        check_eq("dw_terr", timeout_err, m_terr);
        release_strobe(1'b0);
    endtask

    // Backend supplies data on the (delay+1)-th cycle of rd_req, unless the timeout fires first.
    task automatic data_read(input logic [7:0] data, input int delay);
        int n, v, exp_v;
        bit bad;
        logic [7:0] exp_q;
        @(negedge clk_ndf);
        epp_wr_n   = 1'b1;
        epp_dstb_n = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_req && n < 50);
        check_eq("dr_lat", n, SyncStages + 1);
        v   = 0;
        bad = 0;
        while (rd_req && v < 60) begin
            v++;
            if (epp_wait_n || epp_oe || wr_valid) bad = 1;
            if (v - 1 == delay) begin
                rd_valid = 1'b1;
                rd_data  = data;
            end else begin
                rd_data = 8'($urandom);
            end
            tick();
            rd_valid = 1'b0;
        end
        exp_v = (delay < int'(Timeout)) ? delay + 1 : int'(Timeout);
        exp_q = (delay < int'(Timeout)) ? data : TIMEOUT_RD_VAL;
        if (delay >= int'(Timeout)) m_terr = 1'b1;
        check_eq("dr_cycles", v, exp_v);
        check_eq("dr_early", bad, 1'b0);
        check_eq("dr_q", epp_q_o, exp_q);
        check_eq("dr_oe", epp_oe, 1'b1);
        check_eq("dr_wait", epp_wait_n, 1'b1);
        check_eq("dr_terr", timeout_err, m_terr);
        release_strobe(1'b0);
    endtask

    task automatic both_low();
        bit bad;
        @(negedge clk_ndf);
        epp_wr_n   = 1'($urandom);
        epp_astb_n = 1'b0;
        epp_dstb_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wr_valid || rd_req || epp_wait_n || epp_oe) bad = 1;
        end
        @(negedge clk_ndf);
        epp_astb_n = 1'b1;
        epp_dstb_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_valid || rd_req || epp_wait_n || epp_oe) bad = 1;
        end
        check_eq("both_idle", bad, 1'b0);
        check_eq("both_addr", reg_addr, m_addr);
        epp_wr_n = 1'b1;
    endtask

    task automatic reset_in_read();
        int n;
        @(negedge clk_ndf);
        epp_wr_n   = 1'b1;
        epp_dstb_n = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_req && n < 50);
        tick();
        tick();
        check_eq("rr_req_pre", rd_req, 1'b1);
        @(negedge clk_ndf);
        rst = 1'b1;
        #1;
        check_eq("rr_req", rd_req, 1'b0);
        check_eq("rr_oe", epp_oe, 1'b0);
        check_eq("rr_wait", epp_wait_n, 1'b0);
        m_addr = 8'h00;
        m_terr = 1'b0;
        epp_dstb_n = 1'b1;
        tick();
        tick();
        @(negedge clk_ndf);
        rst = 1'b0;
        tick();
        tick();
        check_eq("rr_addr", reg_addr, m_addr);
    endtask

    initial begin
        rst        = 1'b1;
        epp_astb_n = 1'b1;
        epp_dstb_n = 1'b1;
        epp_wr_n   = 1'b1;
        epp_d_i    = 8'h00;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = 8'h00;
        tick();
        tick();
        check_eq("rst_outs", {epp_q_o, epp_oe, epp_wait_n, reg_addr, wr_valid, rd_req,
                              timeout_err}, '0);
        @(negedge clk_ndf);
        rst = 1'b0;
        tick();
        tick();

        // Directed scenarios.
        addr_write(ADDR_CMD);
        data_write(8'h5A, 4);
        data_read(8'hA7, 2);
        data_write(8'h3C, 1000);
        addr_write(ADDR_DATA);
        data_read(8'h11, 30);
        addr_read();
        both_low();
        reset_in_read();
        data_read(8'hC3, 0);
        data_write(8'h99, 0);
        data_write(8'h66, int'(Timeout) - 1);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: addr_write(($urandom_range(0, 1) == 0) ? 8'($urandom)
                                                          : ADDR_ADDR + 8'($urandom_range(0, 4)));
                1: addr_read();
                2: data_write(8'($urandom), int'($urandom_range(0, 18)));
                default: data_read(8'($urandom), int'($urandom_range(0, 18)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
